// File: rtl/multicore_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicore_pkg
// Brief    : Shared types and helpers for the multicore memory subsystem.
// Revision : 1.0 - initial release with the read-arbiter state type
// ============================================================================
package multicore_pkg;

    // Read-arbiter FSM states: idle, AR handshake pending, R burst in flight
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    // Width of an index into a set of n requesters (never zero)
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker. Grants the first requester at
//            or after i_ptr, wrapping around. The pointer is held by the parent.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import multicore_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]            i_req,
    input  logic [ptr_width(N)-1:0] i_ptr,
    output logic [N-1:0]            o_gnt,
    output logic                    o_any
);

    localparam int c_PW = ptr_width(N);

    logic w_found;

    // Scan i_ptr..N-1 first, then 0..i_ptr-1; first hit wins
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_req[i] && (c_PW'(i) >= i_ptr)) begin
                o_gnt[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_req[i] && (c_PW'(i) < i_ptr)) begin
                o_gnt[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_arbiter
// Brief    : Shares one AXI4 read channel among NUM_REQ cache refill engines.
//            Round-robin, one outstanding burst; R beats steered to the owner.
// Revision : 1.0 - initial release
// ============================================================================
module axi_read_arbiter
    import multicore_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_BITS   = 8
) (
    input  logic                          i_aclk,
    input  logic                          i_areset_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]  i_addr,
    input  logic [NUM_REQ*LEN_BITS-1:0]   i_len,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [NUM_REQ-1:0]            o_rvalid,
    output logic [DATA_WIDTH-1:0]         o_rdata,
    output logic                          o_rlast,
    output logic [1:0]                    o_rresp,
    output logic                          o_busy,
    output logic [ADDR_SIZE-1:0]          o_araddr,
    output logic [LEN_BITS-1:0]           o_arlen,
    output logic                          o_arvalid,
    input  logic                          i_arready,
    input  logic                          i_rvalid,
    input  logic [DATA_WIDTH-1:0]         i_rdata,
    input  logic                          i_rlast,
    input  logic [1:0]                    i_rresp,
    output logic                          o_rready
);

    localparam int         c_PW       = ptr_width(NUM_REQ);
    localparam logic [1:0] c_ST_IDLE  = ARB_IDLE;
    localparam logic [1:0] c_ST_ADDR  = ARB_ADDR;
    localparam logic [1:0] c_ST_DATA  = ARB_DATA;

    logic [1:0]           r_state;
    logic [c_PW-1:0]      r_rr_ptr;
    logic [c_PW-1:0]      r_owner;
    logic [ADDR_SIZE-1:0] r_araddr;
    logic [LEN_BITS-1:0]  r_arlen;

    logic [NUM_REQ-1:0]   w_gnt;
    logic                 w_any;
    logic [c_PW-1:0]      w_pick;
    logic [ADDR_SIZE-1:0] w_pick_addr;
    logic [LEN_BITS-1:0]  w_pick_len;
    logic [NUM_REQ-1:0]   w_owner_oh;
    logic [c_PW-1:0]      w_next_ptr;
    logic                 w_in_addr;
    logic                 w_in_data;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .i_req (i_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_any (w_any)
    );

    // Turn the one-hot winner into an index and select its address/length
    always_comb begin
        w_pick      = '0;
        w_pick_addr = '0;
        w_pick_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_pick      = c_PW'(i);
                w_pick_addr = i_addr[i*ADDR_SIZE +: ADDR_SIZE];
                w_pick_len  = i_len[i*LEN_BITS +: LEN_BITS];
            end
        end
    end

    // One-hot view of the burst owner for grant and beat steering
    always_comb begin
        w_owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_owner_oh[i] = (r_owner == c_PW'(i));
        end
    end

    // Pointer moves just past the owner so it loses the next contention
    assign w_next_ptr = (r_owner == c_PW'(NUM_REQ - 1)) ? '0 : r_owner + c_PW'(1);

    // Burst sequencing: IDLE -> ADDR (AR handshake) -> DATA (until rlast)
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state  <= c_ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_araddr <= '0;
            r_arlen  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_owner  <= w_pick;
                        r_araddr <= w_pick_addr;
                        r_arlen  <= w_pick_len;
                        r_state  <= c_ST_ADDR;
                    end
                end
                c_ST_ADDR: begin
                    if (i_arready) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (i_rvalid && i_rlast) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign w_in_addr = (r_state == c_ST_ADDR);
    assign w_in_data = (r_state == c_ST_DATA);

    assign o_arvalid = w_in_addr;
    assign o_araddr  = r_araddr;
    assign o_arlen   = r_arlen;
    assign o_grant   = (w_in_addr && i_arready) ? w_owner_oh : '0;
    assign o_rready  = w_in_data;
    assign o_rvalid  = (w_in_data && i_rvalid) ? w_owner_oh : '0;
    assign o_rlast   = w_in_data && i_rvalid && i_rlast;
    assign o_rdata   = i_rdata;
    assign o_rresp   = i_rresp;
    assign o_busy    = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
